// File: rtl/nabp_angle_lut_if.sv
// rtl/nabp_angle_lut_if.sv - angle request / coefficient response bundle for nabp_angle_lut
// master drives the angle and reads the coefficients; slave is the LUT side.
interface nabp_angle_lut_if #(
   parameter int ANGLE_WIDTH = 8,
   parameter int BASE_WIDTH  = 10,
   parameter int PART_WIDTH  = 14
) ();
   logic [ANGLE_WIDTH-1:0] angle;
   logic [PART_WIDTH-1:0]  mp_accu_part;
   logic [BASE_WIDTH-1:0]  mp_accu_base;
   logic [BASE_WIDTH-1:0]  sh_accu_base;

   modport master (
      output angle,
      input  mp_accu_part,
      input  mp_accu_base,
      input  sh_accu_base
   );

   modport slave (
      input  angle,
      output mp_accu_part,
      output mp_accu_base,
      output sh_accu_base
   );
endinterface

// File: rtl/nabp_angle_lut.sv
// rtl/nabp_angle_lut.sv - per-angle mapper/shifter coefficient ROM for NABP swap control
// One registered lookup per cycle; angles >= 180 return all zeros.
module nabp_angle_lut #(
   parameter int ANGLE_WIDTH    = 8,
   parameter int FRAC_BITS      = 8,
   parameter int BASE_WIDTH     = FRAC_BITS + 2,
   parameter int PART_SIZE_LOG2 = 4,
   parameter int PART_WIDTH     = BASE_WIDTH + PART_SIZE_LOG2
) (
   input  logic              clk,
   input  logic              reset_n,
   nabp_angle_lut_if.slave   lut
);
   localparam int ANGLE_COUNT = 180;
   localparam int ENTRY_W     = 2 * BASE_WIDTH;
   localparam int ROM_BITS    = ANGLE_COUNT * ENTRY_W;
   localparam int Q           = 30;
   localparam longint ONE     = longint'(1) <<< Q;
   localparam longint PI_Q    = 64'sd3373259426;
   localparam longint HALF    = longint'(1) <<< (Q - FRAC_BITS - 1);

   // Elaboration-time table build: Q30 Taylor series on the reference angle
   // (0..90), so the hardware only holds constants. Entry = {sh_base, mp_base}.
   function automatic logic [ROM_BITS-1:0] build_rom();
      logic [ROM_BITS-1:0] rom;
      longint x, x2, s, c, term, base_q, ratio;
      int     a;
      rom = '0;
      for (int th = 0; th < ANGLE_COUNT; th++) begin
         a  = (th <= 90) ? th : 180 - th;
         x  = (longint'(a) * PI_Q) / 180;
         x2 = (x * x) >>> Q;
         s    = x;
         term = x;
         for (int k = 1; k <= 12; k++) begin
            term = -(((term * x2) >>> Q) / longint'((2 * k) * (2 * k + 1)));
            s    = s + term;
         end
         c    = ONE;
         term = ONE;
         for (int k = 1; k <= 12; k++) begin
            term = -(((term * x2) >>> Q) / longint'((2 * k - 1) * (2 * k)));
            c    = c + term;
         end
         if (th < 45 || th >= 135) begin
            base_q = c;
            ratio  = (s <<< Q) / c;
         end else begin
            base_q = s;
            ratio  = (c <<< Q) / s;
         end
         rom[th*ENTRY_W +: BASE_WIDTH] =
            BASE_WIDTH'((base_q + HALF) >>> (Q - FRAC_BITS));
         rom[th*ENTRY_W + BASE_WIDTH +: BASE_WIDTH] =
            BASE_WIDTH'((ratio + HALF) >>> (Q - FRAC_BITS));
      end
      return rom;
   endfunction

   localparam logic [ROM_BITS-1:0] ROM = build_rom();

   logic [ENTRY_W-1:0] entry;

   always_comb begin
      entry = '0;
      if (int'(lut.angle) < ANGLE_COUNT) begin
         entry = ROM[int'(lut.angle)*ENTRY_W +: ENTRY_W];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lut.mp_accu_base <= '0;
         lut.sh_accu_base <= '0;
      end else begin
         lut.mp_accu_base <= entry[BASE_WIDTH-1:0];
         lut.sh_accu_base <= entry[ENTRY_W-1:BASE_WIDTH];
      end
   end

   // Partition init is the per-line step scaled by the partition size: pure wiring.
   assign lut.mp_accu_part = {lut.mp_accu_base, {PART_SIZE_LOG2{1'b0}}};

endmodule

// File: tb/tb_nabp_angle_lut.sv
// tb/tb_nabp_angle_lut.sv - scoreboard bench for nabp_angle_lut against a trig reference model
module tb_nabp_angle_lut;
   localparam real PI = 3.14159265358979323846;

   typedef struct {
      int    angle;
      int    mp;
      int    sh;
      int    part;
      string name;
   } exp_t;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_pass;
   exp_t sb[$];

   nabp_angle_lut_if #(.ANGLE_WIDTH(8), .BASE_WIDTH(10), .PART_WIDTH(14)) lut ();

   nabp_angle_lut dut (
      .clk     (clk),
      .reset_n (reset_n),
      .lut     (lut.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int rnd(input real v);
      return int'($floor(v * 256.0 + 0.5));
   endfunction

   // Reference: straight from the trig definitions in double precision.
   function automatic void model(input int th, output int mp, output int sh);
      real r, s, c;
      mp = 0;
      sh = 0;
      if (th < 180) begin
         r = real'(th) * PI / 180.0;
         s = $sin(r);
         c = $cos(r);
         if (s < 0.0) s = -s;
         if (c < 0.0) c = -c;
         if (th >= 45 && th < 135) begin
            mp = rnd(s);
            sh = rnd(c / s);
         end else begin
            mp = rnd(c);
            sh = rnd(s / c);
         end
      end
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   task automatic issue_const(input int a, input int mp, input int sh, input int part,
                              input string name);
      exp_t e;
      lut.angle = 8'(a);
      e.angle = a; e.mp = mp; e.sh = sh; e.part = part; e.name = name;
      sb.push_back(e);
   endtask

   task automatic issue_model(input int a, input string name);
      int mp, sh;
      model(a, mp, sh);
      issue_const(a, mp, sh, mp * 16, name);
   endtask

   task automatic drive_const(input int a, input int mp, input int sh, input int part,
                              input string name);
      @(negedge clk);
      issue_const(a, mp, sh, part, name);
   endtask

   task automatic drive_model(input int a, input string name);
      @(negedge clk);
      issue_model(a, name);
   endtask

   // Monitor: one response per cycle, one cycle after the angle was driven.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("%s a=%0d mp_accu_base", e.name, e.angle), int'(lut.mp_accu_base), e.mp);
         check($sformatf("%s a=%0d sh_accu_base", e.name, e.angle), int'(lut.sh_accu_base), e.sh);
         check($sformatf("%s a=%0d mp_accu_part", e.name, e.angle), int'(lut.mp_accu_part), e.part);
         check($sformatf("%s a=%0d part_is_base_x16", e.name, e.angle),
               int'(lut.mp_accu_part), int'(lut.mp_accu_base) * 16);
         check($sformatf("%s a=%0d sh_le_one", e.name, e.angle),
               int'(lut.sh_accu_base <= 10'd256), 1);
      end
   end

   task automatic check_zero(input string name);
      check({name, " mp_accu_base"}, int'(lut.mp_accu_base), 0);
      check({name, " sh_accu_base"}, int'(lut.sh_accu_base), 0);
      check({name, " mp_accu_part"}, int'(lut.mp_accu_part), 0);
   endtask

   task automatic wait_drain(input string name);
      int budget;
      budget = 20;
      while (sb.size() > 0 && budget > 0) begin
         @(posedge clk);
         #2;
         budget--;
      end
      check({name, " drain"}, sb.size(), 0);
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      reset_n   = 1'b1;
      lut.angle = 8'd30;
      #2;
      reset_n = 1'b0;
      #1;
      check_zero("async_reset");
      repeat (2) @(posedge clk);
      #1;
      check_zero("held_reset");

      @(negedge clk);
      reset_n = 1'b1;
      issue_const(30, 222, 148, 3552, "reset_release");

      drive_const(0,   256, 0,   4096, "theta0");
      drive_const(45,  181, 256, 2896, "theta45");
      drive_const(44,  184, 247, 2944, "theta44");
      drive_const(90,  256, 0,   4096, "theta90");
      drive_const(135, 181, 256, 2896, "theta135");
      drive_const(0,   256, 0,   4096, "stream0");
      drive_const(45,  181, 256, 2896, "stream45");
      drive_const(90,  256, 0,   4096, "stream90");
      drive_const(135, 181, 256, 2896, "stream135");
      drive_const(200, 0,   0,   0,    "out_of_range");

      for (int a = 0; a < 180; a++) drive_model(a, "sweep");
      for (int i = 0; i < 200; i++) drive_model(int'($urandom_range(0, 255)), "random");

      drive_const(30, 222, 148, 3552, "pre_reset");
      wait_drain("pre_reset");
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_zero("mid_reset");
      @(negedge clk);
      reset_n = 1'b1;
      issue_model(77, "post_reset");
      for (int i = 0; i < 50; i++) drive_model(int'($urandom_range(0, 255)), "random2");

      wait_drain("final");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
